// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between I$ fills and D$ accesses: one transaction at a time,
// D$ has fixed priority, and a starvation counter guarantees the I$ eventually gets the port.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int LOG_STARVE   = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,

   input  logic                  icache_REN,
   input  logic [ADDR_WIDTH-1:0] icache_addr,
   input  logic                  icache_halt,
   output logic                  iwait,
   output logic [31:0]           iload,

   input  logic                  dcache_REN,
   input  logic                  dcache_WEN,
   input  logic [ADDR_WIDTH-1:0] dcache_addr,
   input  logic [31:0]           dcache_store,
   output logic                  dwait,
   output logic [31:0]           dload,

   output logic                  ram_REN,
   output logic                  ram_WEN,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_store,
   input  logic                  ram_ready,
   input  logic [31:0]           ram_load
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } state_t;

   localparam logic [LOG_STARVE-1:0] STARVE_MAX = LOG_STARVE'(STARVE_LIMIT);

   state_t                state;
   logic [LOG_STARVE-1:0] starve_cnt;
   logic                  i_elig;
   logic                  d_elig;
   logic                  starved;

   assign i_elig  = icache_REN & ~icache_halt;
   assign d_elig  = dcache_REN | dcache_WEN;
   assign starved = (starve_cnt == STARVE_MAX);

   // Every grant returns to IDLE on completion, so there is always one idle
   // cycle between grants in which the requester can drop its request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_elig && starved)
                  state <= IGRANT;
               else if (d_elig)
                  state <= DGRANT;
               else if (i_elig)
                  state <= IGRANT;
            end
            IGRANT: begin
               if (ram_ready) begin
                  state      <= IDLE;
                  starve_cnt <= '0;
               end
            end
            DGRANT: begin
               if (ram_ready) begin
                  state <= IDLE;
                  // Saturates so a long D$ burst can never wrap the counter back to 0.
                  if (i_elig && !starved)
                     starve_cnt <= starve_cnt + LOG_STARVE'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are decoded from the grant state so completion is visible in the ready cycle.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
      ram_REN   = 1'b0;
      ram_WEN   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      iwait     = 1'b1;
      dwait     = 1'b1;
      iload     = '0;
      dload     = '0;
      case (state)
         IGRANT: begin
            ram_REN  = icache_REN;
            ram_addr = icache_addr;
            if (ram_ready) begin
               iwait = 1'b0;
               iload = ram_load;
            end
         end
         DGRANT: begin
            ram_WEN   = dcache_WEN;
            ram_REN   = dcache_REN & ~dcache_WEN;
            ram_addr  = dcache_addr;
            ram_store = dcache_store;
            if (ram_ready) begin
               dwait = 1'b0;
               if (dcache_REN && !dcache_WEN)
                  dload = ram_load;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between I$ miss fills and D$ loads/stores/writebacks.
- Sits between icache/dcache and RAM inside the core memory subsystem.
- One transaction at a time, sequenced by a grant FSM.
- D$ has fixed priority, with a starvation counter that guarantees I$ forward progress for the fetch unit.

Parameters:
- ADDR_WIDTH, 32, byte address width of all address ports.
- STARVE_LIMIT, 4, number of consecutive D$ grants allowed while an I$ request is pending. Must be ≥1.
- LOG_STARVE, $clog2(STARVE_LIMIT+1), starvation counter width (calculated).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- icache_REN  in  1  I$ fill read request (level; held until iwait falls)
- icache_addr  in  ADDR_WIDTH  I$ request address
- icache_halt  in  1  blocks new I$ grants (pipeline halt)
- iwait  out  1  1 = I$ request not yet complete
- iload  out  32  I$ read data, valid when icache_REN & ~iwait
- dcache_REN  in  1  D$ read request (level)
- dcache_WEN  in  1  D$ write request (level)
- dcache_addr  in  ADDR_WIDTH  D$ request address
- dcache_store  in  32  D$ write data
- dwait  out  1  1 = D$ request not yet complete
- dload  out  32  D$ read data, valid when dcache_REN & ~dwait
- ram_REN  out  1  RAM read enable
- ram_WEN  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_store  out  32  RAM write data
- ram_ready  in  1  RAM completes the current access this cycle
- ram_load  in  32  RAM read data, valid with ram_ready

Behaviour:
- FSM states: IDLE, IGRANT, DGRANT. State and starvation counter are registered.
- Reset: state=IDLE, starve_cnt=0. All outputs combinational from state, so in reset/IDLE: ram_REN=ram_WEN=0, ram_addr=0, ram_store=0, iwait=dwait=1, iload=dload=0.
- Reset asserted mid-transaction: FSM returns to IDLE next edge with no completion pulse; the RAM access is abandoned.
- I$ request is eligible when icache_REN & ~icache_halt. D$ request is eligible when dcache_REN | dcache_WEN.
- IDLE grant selection, decided in the cycle the request is seen, registered on the next edge:
  - I$ eligible & starve_cnt==STARVE_LIMIT -> IGRANT.
  - Else D$ eligible -> DGRANT.
  - Else I$ eligible -> IGRANT.
  - Else stay IDLE.
- Minimum latency from request to first RAM enable: 1 cycle.
- IGRANT:
  - ram_REN=1, ram_addr=icache_addr.
  - On ram_ready: iwait=0 and iload=ram_load in the same cycle, next state IDLE, starve_cnt cleared to 0.
- DGRANT:
  - ram_WEN=dcache_WEN, ram_REN=dcache_REN & ~dcache_WEN (WEN wins if both are set), ram_addr=dcache_addr, ram_store=dcache_store.
  - On ram_ready: dwait=0 and dload=ram_load (read only), next state IDLE.
  - Starvation counter on D$ completion: if an I$ request is eligible, starve_cnt increments, saturating at STARVE_LIMIT; otherwise it holds.
- After every completion there is exactly one IDLE cycle before the next grant (no back-to-back grants). This IDLE cycle gives the requester time to drop its request.
- Requester drops its request during its grant: the grant holds with RAM enables following the (now 0) request inputs until ram_ready, then returns to IDLE. The completion pulse is ignored.
- icache_halt rising during IGRANT does not abort; the transaction finishes normally.
- Only the owner's wait signal can fall; the non-granted wait stays 1.
- Wait outputs are 1 whenever not completing, including IDLE.
- ram_ready in IDLE is ignored.
- Widths: the counter saturates and never wraps. Addresses pass through unmodified.

Test Plan:
- Reset: hold RST=1 for 2 cycles with all requests high -> ram_REN=ram_WEN=0, iwait=dwait=1, state IDLE. After release, the first grant appears on cycle 1.
- Single I$ read: icache_REN=1, icache_addr=0x0000_0040, ram_ready after 3 cycles with ram_load=0x8C41_0004 -> ram_REN=1, ram_addr=0x40 from cycle 1; iwait=0 and iload=0x8C41_0004 exactly in the ready cycle; IDLE next.
- Simultaneous requests: I$ read 0x100 and D$ write 0x200/0xDEAD_BEEF both requested at cycle 0 -> DGRANT first, with ram_WEN=1 and ram_store=0xDEADBEEF. After its completion, one IDLE cycle, then IGRANT with ram_addr=0x100.
- Starvation, STARVE_LIMIT=4: D$ requests continuously and I$ held pending -> exactly 4 D$ completions, then IGRANT, with starve_cnt back to 0 after the I$ completes.
- icache_halt=1 with icache_REN=1 and no D$ request -> FSM stays IDLE indefinitely and iwait=1. Deasserting halt -> IGRANT on the next edge.
- Reset mid-DGRANT with ram_ready never asserted -> IDLE after the reset edge, dwait stays 1, no ram_WEN afterwards until a new grant.
